// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and a
// width helper used to size index and counter fields.
package mem_port_arbiter_pkg;

    // Arbiter states; the encoding is visible on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    // Bits needed to hold values 0..value-1, never less than one bit so that
    // degenerate parameterisations still produce legal vectors.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int v = 1; v < value; v = v * 2) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from the
// pointer upward with wrap-around.
module rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int width = 4,
    parameter int idx_w = clog2_min1(width)
) (
    input  logic [idx_w-1:0] in_ptr,
    input  logic [width-1:0] in_req,
    output logic [width-1:0] out_onehot,
    output logic [idx_w-1:0] out_idx,
    output logic             out_any
);

    int scan_pos;

    // Walk width positions starting at the pointer; the first hit wins.
    always_comb begin
        out_onehot = '0;
        out_idx    = '0;
        out_any    = 1'b0;
        scan_pos   = 0;
        for (int i = 0; i < width; i++) begin
            scan_pos = (int'(in_ptr) + i) % width;
            if (!out_any && in_req[scan_pos]) begin
                out_any              = 1'b1;
                out_idx              = idx_w'(scan_pos);
                out_onehot[scan_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Locking round-robin arbiter for the single shared memory port. A granted
// PU owns the port until it drops its request or its hold budget runs out;
// a one-cycle turnaround always separates two owners.
//
// Handshake: in_request is a level; out_grant rises the cycle after the
// arbiter accepts it and stays high while the PU keeps requesting (bounded
// by max_hold). Only the owner's strobes reach memory; read data is valid on
// out_read_valid one cycle after an accepted read strobe.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int  width      = 4,
    parameter int  log_size   = 10,
    parameter int  data_width = 96,
    parameter int  max_hold   = 64,
    localparam int idx_w      = clog2_min1(width)
) (
    input  logic                        in_clk,
    input  logic                        in_reset,
    input  logic [width-1:0]            in_request,
    input  logic [width*log_size-1:0]   in_address,
    input  logic [width*data_width-1:0] in_data,
    input  logic [width-1:0]            in_read_en,
    input  logic [width-1:0]            in_write_en,
    output logic [width-1:0]            out_grant,
    output logic [width-1:0]            out_read_valid,
    output logic [width-1:0]            out_preempt,
    output logic [log_size-1:0]         out_mem_address,
    output logic [data_width-1:0]       out_mem_data,
    output logic                        out_mem_read_en,
    output logic                        out_mem_write_en,
    output logic [1:0]                  out_dbg_state,
    output logic [idx_w-1:0]            out_dbg_ptr
);

    localparam int hold_w = clog2_min1(max_hold + 1);

    arb_state_e         state_q, state_d;
    logic [width-1:0]   grant_q, grant_d;
    logic [idx_w-1:0]   owner_q, owner_d;
    logic [idx_w-1:0]   ptr_q, ptr_d;
    logic [hold_w-1:0]  hold_q, hold_d;
    logic [width-1:0]   read_valid_q, read_valid_d;
    logic [width-1:0]   preempt_q, preempt_d;

    logic [width-1:0]   pick_onehot;
    logic [idx_w-1:0]   pick_idx;
    logic               pick_any;
    logic [idx_w-1:0]   next_ptr;

    logic               owning;
    logic               owner_req;
    logic               owner_rd;
    logic               owner_wr;
    logic               hold_expired;

    rr_pick #(
        .width (width),
        .idx_w (idx_w)
    ) u_rr_pick (
        .in_ptr     (ptr_q),
        .in_req     (in_request),
        .out_onehot (pick_onehot),
        .out_idx    (pick_idx),
        .out_any    (pick_any)
    );

    // Owner's view of the request/strobe inputs and the hold-budget test.
    always_comb begin
        owning       = (state_q == ST_GRANT);
        owner_req    = in_request[owner_q];
        owner_rd     = in_read_en[owner_q];
        owner_wr     = in_write_en[owner_q];
        hold_expired = (max_hold != 0) && (int'(hold_q) == max_hold - 1);
        next_ptr     = (int'(pick_idx) == width - 1) ? '0 : pick_idx + 1'b1;
    end

    // Port mux: only the registered owner drives memory, and only in GRANT.
    // A simultaneous read and write from the owner resolves to the write.
    always_comb begin
        out_mem_address  = '0;
        out_mem_data     = '0;
        out_mem_read_en  = 1'b0;
        out_mem_write_en = 1'b0;
        if (owning) begin
            out_mem_address  = in_address[owner_q*log_size +: log_size];
            out_mem_data     = in_data[owner_q*data_width +: data_width];
            out_mem_write_en = owner_wr;
            out_mem_read_en  = owner_rd & ~owner_wr;
        end
    end

    // Next-state logic for the arbiter FSM, hold counter and pulse outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        preempt_d    = '0;
        read_valid_d = '0;

        // Memory answers one cycle after an accepted read strobe.
        if (owning && owner_rd && !owner_wr) begin
            read_valid_d[owner_q] = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_TURN: begin
                grant_d = '0;
                state_d = ST_IDLE;
                if (pick_any) begin
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    ptr_d   = next_ptr;
                    hold_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    grant_d = '0;
                    state_d = ST_TURN;
                end else if (hold_expired) begin
                    grant_d            = '0;
                    preempt_d[owner_q] = 1'b1;
                    state_d            = ST_TURN;
                end else if ((max_hold != 0) && (hold_q != '1)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            ptr_q        <= '0;
            hold_q       <= '0;
            read_valid_q <= '0;
            preempt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            read_valid_q <= read_valid_d;
            preempt_q    <= preempt_d;
        end
    end

    assign out_grant      = grant_q;
    assign out_read_valid = read_valid_q;
    assign out_preempt    = preempt_q;
    assign out_dbg_state  = state_q;
    assign out_dbg_ptr    = ptr_q;

endmodule
